led_matrix_status_scanner: RTL and testbench

Time-multiplexed driver for the irrigation status LED matrix. It generalises the per-column status decoders into one parametrised block that scans NUM_COLS columns and looks up each column's row pattern from a glyph table indexed by status code. It also provides tear-free status updates at frame boundaries, anti-ghosting dead time and an optional blink mode. It sits between the irrigation controller's status output and the matrix pins.

---
 rtl/led_matrix_pkg.sv | 38 +++
 rtl/led_matrix_status_scanner_rom.sv | 25 ++
 rtl/led_matrix_status_scanner.sv | 140 ++++++++++++++
 tb/tb_led_matrix_status_scanner.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared definitions for the irrigation status LED matrix: status codes,
// glyph table, blink phase type and small lookup helpers.
package led_matrix_pkg;

    localparam int unsigned STATUS_OFF       = 0;
    localparam int unsigned STATUS_WATERING  = 1;
    localparam int unsigned STATUS_ERROR     = 2;
    localparam int unsigned STATUS_LOW_WATER = 3;

    localparam int unsigned GLYPH_STATUS = 4;
    localparam int unsigned GLYPH_COLS   = 5;
    localparam int unsigned GLYPH_ROWS   = 7;
    localparam int unsigned GLYPH_SW     = $clog2(GLYPH_STATUS);
    localparam int unsigned GLYPH_CW     = $clog2(GLYPH_COLS);

    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } blink_phase_e;

    // Row bit 0 is the top LED; indexed [status][column].
    localparam logic [GLYPH_ROWS-1:0] GLYPH [GLYPH_STATUS][GLYPH_COLS] = '{
        '{7'b0111110, 7'b1000001, 7'b1000001, 7'b1000001, 7'b0111110},
        '{7'b0011000, 7'b0111100, 7'b1111111, 7'b0111100, 7'b0011000},
        '{7'b1100011, 7'b0010100, 7'b0001000, 7'b0010100, 7'b1100011},
        '{7'b1000000, 7'b1100000, 7'b1110000, 7'b1100000, 7'b1000000}
    };

    function automatic logic [31:0] onehot(input logic [31:0] col);
        return 32'(1) << col;
    endfunction

    function automatic logic [GLYPH_ROWS-1:0] glyph_word(input logic [GLYPH_SW-1:0] s,
                                                          input logic [GLYPH_CW-1:0] c);
        return GLYPH[s][c];
    endfunction

endpackage

// File: rtl/led_matrix_status_scanner_rom.sv
// Combinational glyph lookup: row pattern for one status code and column,
// blank for undefined codes or columns outside the glyph table.
module status_glyph_rom
    import led_matrix_pkg::*;
#(
    parameter int unsigned NUM_COLS   = 5,
    parameter int unsigned NUM_ROWS   = 7,
    parameter int unsigned STATUS_W   = 2,
    parameter int unsigned NUM_STATUS = 4,
    parameter int unsigned COL_W      = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic [STATUS_W-1:0] status_i,
    input  logic [COL_W-1:0]    col_i,
    output logic [NUM_ROWS-1:0] rows_o
);

    always_comb begin
        rows_o = '0;
        if (32'(status_i) < NUM_STATUS && 32'(status_i) < GLYPH_STATUS &&
            32'(col_i) < NUM_COLS && 32'(col_i) < GLYPH_COLS) begin
            rows_o = NUM_ROWS'(glyph_word(GLYPH_SW'(status_i), GLYPH_CW'(col_i)));
        end
    end

endmodule

// File: rtl/led_matrix_status_scanner.sv
// Column-multiplexed LED matrix driver with frame-aligned status updates,
// per-slot anti-ghosting dead time and optional blink.
module led_matrix_status_scanner
    import led_matrix_pkg::*;
#(
    parameter int unsigned NUM_COLS     = 5,
    parameter int unsigned NUM_ROWS     = 7,
    parameter int unsigned STATUS_W     = 2,
    parameter int unsigned NUM_STATUS   = 4,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEAD_CYCLES  = 2,
    parameter int unsigned BLINK_FRAMES = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [STATUS_W-1:0] status_in,
    input  logic                status_valid,
    input  logic                blink_en,
    output logic [NUM_COLS-1:0] columns_out,
    output logic [NUM_ROWS-1:0] rows_out,
    output logic                frame_start,
    output logic                status_pending
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [COL_W-1:0]    col_idx_q, col_idx_d;
    logic [STATUS_W-1:0] active_q, active_d;
    logic [STATUS_W-1:0] pending_q, pending_d;
    logic                pend_flag_q, pend_flag_d;
    logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
    blink_phase_e        phase_q, phase_d;
    logic [NUM_COLS-1:0] columns_q, columns_d;
    logic [NUM_ROWS-1:0] rows_q, rows_d;
    logic                frame_start_q, frame_start_d;

    logic                div_wrap_c;
    logic                frame_wrap_c;
    logic                gate_open_c;
    logic [NUM_ROWS-1:0] glyph_rows_c;

    status_glyph_rom #(
        .NUM_COLS   (NUM_COLS),
        .NUM_ROWS   (NUM_ROWS),
        .STATUS_W   (STATUS_W),
        .NUM_STATUS (NUM_STATUS),
        .COL_W      (COL_W)
    ) u_rom (
        .status_i (active_q),
        .col_i    (col_idx_q),
        .rows_o   (glyph_rows_c)
    );

    assign div_wrap_c   = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    assign frame_wrap_c = div_wrap_c && (col_idx_q == COL_W'(NUM_COLS - 1));
    // blink_en is used live so dropping it reopens the gate on the next edge.
    assign gate_open_c  = !blink_en || (phase_q == PHASE_ON);

    always_comb begin
        div_cnt_d     = div_wrap_c ? '0 : div_cnt_q + DIV_W'(1);
        col_idx_d     = col_idx_q;
        active_d      = active_q;
        pending_d     = pending_q;
        pend_flag_d   = pend_flag_q;
        blink_cnt_d   = blink_cnt_q;
        phase_d       = phase_q;
        columns_d     = NUM_COLS'(onehot(32'(col_idx_q)));
        frame_start_d = (div_cnt_q == '0) && (col_idx_q == '0);
        rows_d        = '0;

        if (div_wrap_c) begin
            col_idx_d = frame_wrap_c ? '0 : col_idx_q + COL_W'(1);
        end

        // A capture landing on the wrap edge goes straight to the display.
        if (status_valid) begin
            if (frame_wrap_c) begin
                active_d    = status_in;
                pend_flag_d = 1'b0;
            end else begin
                pending_d   = status_in;
                pend_flag_d = 1'b1;
            end
        end else if (frame_wrap_c && pend_flag_q) begin
            active_d    = pending_q;
            pend_flag_d = 1'b0;
        end

        if (!blink_en) begin
            blink_cnt_d = '0;
            phase_d     = PHASE_ON;
        end else if (frame_wrap_c) begin
            if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end

        if (32'(div_cnt_q) >= DEAD_CYCLES && gate_open_c) begin
            rows_d = glyph_rows_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            col_idx_q     <= '0;
            active_q      <= '0;
            pending_q     <= '0;
            pend_flag_q   <= 1'b0;
            blink_cnt_q   <= '0;
            phase_q       <= PHASE_ON;
            columns_q     <= '0;
            rows_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            col_idx_q     <= col_idx_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            pend_flag_q   <= pend_flag_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
            columns_q     <= columns_d;
            rows_q        <= rows_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign columns_out    = columns_q;
    assign rows_out       = rows_q;
    assign frame_start    = frame_start_q;
    assign status_pending = pend_flag_q;

endmodule

// File: tb/tb_led_matrix_status_scanner.sv
// Bench for led_matrix_status_scanner: a cycle-count based reference model,
// a directed vector table for the basic scan and hand sequences for corners.
module tb_led_matrix_status_scanner;

    localparam int NC    = 5;
    localparam int SD    = 4;
    localparam int DC    = 1;
    localparam int BF    = 2;
    localparam int FRAME = NC * SD;

    logic       clk;
    logic       rst_n;
    logic [1:0] status_in;
    logic       status_valid;
    logic       blink_en;
    logic [4:0] cols, cols3;
    logic [6:0] rows, rows3;
    logic       fs, fs3, pend, pend3;

    led_matrix_status_scanner #(
        .NUM_COLS(5), .NUM_ROWS(7), .STATUS_W(2), .NUM_STATUS(4),
        .SCAN_DIV(SD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .status_in(status_in), .status_valid(status_valid),
        .blink_en(blink_en), .columns_out(cols), .rows_out(rows),
        .frame_start(fs), .status_pending(pend)
    );

    led_matrix_status_scanner #(
        .NUM_COLS(5), .NUM_ROWS(7), .STATUS_W(2), .NUM_STATUS(3),
        .SCAN_DIV(SD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .status_in(status_in), .status_valid(status_valid),
        .blink_en(blink_en), .columns_out(cols3), .rows_out(rows3),
        .frame_start(fs3), .status_pending(pend3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [6:0] ref_glyph [4][5];

    // Reference model state: m_step counts scan cycles since reset release.
    int         m_step, m_last, m_active, m_pend_val, m_wraps;
    bit         m_pend;
    logic [4:0] e_cols;
    logic [6:0] e_rows, e_rows3;
    logic       e_fs, e_pend;

    typedef struct {
        int         k;
        logic [4:0] cols;
        logic [6:0] rows;
        logic       fs;
    } vec_t;
    localparam int NV = 11;
    vec_t vecs [NV];

    function automatic logic [6:0] glyph_ref(input int st, input int col, input int nstat);
        if (st >= nstat) return 7'b0;
        return ref_glyph[st][col];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, m_last);
    endtask

    task automatic model_edge();
        int div, col;
        bit wrap, gate;
        if (!rst_n) begin
            m_step = 0; m_last = -1; m_active = 0; m_pend_val = 0; m_pend = 0; m_wraps = 0;
            e_cols = '0; e_rows = '0; e_rows3 = '0; e_fs = 1'b0; e_pend = 1'b0;
        end else begin
            div  = m_step % SD;
            col  = (m_step / SD) % NC;
            wrap = (m_step % FRAME) == FRAME - 1;
            gate = !blink_en || ((m_wraps / BF) % 2 == 0);
            e_cols  = 5'(1 << col);
            e_fs    = (m_step % FRAME) == 0;
            e_rows  = (div >= DC && gate) ? glyph_ref(m_active, col, 4) : 7'b0;
            e_rows3 = (div >= DC && gate) ? glyph_ref(m_active, col, 3) : 7'b0;
            if (status_valid) begin
                if (wrap) begin
                    m_active = int'(status_in);
                    m_pend   = 0;
                end else begin
                    m_pend_val = int'(status_in);
                    m_pend     = 1;
                end
            end else if (wrap && m_pend) begin
                m_active = m_pend_val;
                m_pend   = 0;
            end
            if (!blink_en) m_wraps = 0;
            else if (wrap) m_wraps++;
            e_pend = m_pend;
            m_last = m_step;
            m_step++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("cols",  32'(cols),  32'(e_cols));
        check("rows",  32'(rows),  32'(e_rows));
        check("fs",    32'(fs),    32'(e_fs));
        check("pend",  32'(pend),  32'(e_pend));
        check("cols3", 32'(cols3), 32'(e_cols));
        check("rows3", 32'(rows3), 32'(e_rows3));
    endtask

    task automatic run_until_last(input int t);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((m_last % FRAME) != t && n < 200);
        check("sync", 32'(m_last % FRAME), 32'(t));
    endtask

    initial begin
        ref_glyph[0] = '{7'b0111110, 7'b1000001, 7'b1000001, 7'b1000001, 7'b0111110};
        ref_glyph[1] = '{7'b0011000, 7'b0111100, 7'b1111111, 7'b0111100, 7'b0011000};
        ref_glyph[2] = '{7'b1100011, 7'b0010100, 7'b0001000, 7'b0010100, 7'b1100011};
        ref_glyph[3] = '{7'b1000000, 7'b1100000, 7'b1110000, 7'b1100000, 7'b1000000};

        vecs[0]  = '{1,  5'b00001, 7'b0000000, 1'b1};
        vecs[1]  = '{2,  5'b00001, 7'b0111110, 1'b0};
        vecs[2]  = '{4,  5'b00001, 7'b0111110, 1'b0};
        vecs[3]  = '{5,  5'b00010, 7'b0000000, 1'b0};
        vecs[4]  = '{6,  5'b00010, 7'b1000001, 1'b0};
        vecs[5]  = '{13, 5'b01000, 7'b0000000, 1'b0};
        vecs[6]  = '{18, 5'b10000, 7'b0111110, 1'b0};
        vecs[7]  = '{20, 5'b10000, 7'b0111110, 1'b0};
        vecs[8]  = '{21, 5'b00001, 7'b0000000, 1'b1};
        vecs[9]  = '{22, 5'b00001, 7'b0111110, 1'b0};
        vecs[10] = '{41, 5'b00001, 7'b0000000, 1'b1};

        rst_n = 1'b0; status_valid = 1'b0; status_in = 2'd0; blink_en = 1'b0;
        tick();
        tick();
        check("rst_cols", 32'(cols), 32'd0);
        check("rst_rows", 32'(rows), 32'd0);
        check("rst_fs",   32'(fs),   32'd0);
        check("rst_pend", 32'(pend), 32'd0);
        rst_n = 1'b1;

        // Basic scan with status 0, checked against the directed table.
        for (int k = 1; k <= 41; k++) begin
            tick();
            for (int v = 0; v < NV; v++) begin
                if (vecs[v].k == k) begin
                    check("vec_cols", 32'(cols), 32'(vecs[v].cols));
                    check("vec_rows", 32'(rows), 32'(vecs[v].rows));
                    check("vec_fs",   32'(fs),   32'(vecs[v].fs));
                end
            end
        end

        // Mid-frame capture is held until the frame boundary.
        run_until_last(9);
        status_valid = 1'b1; status_in = 2'd2;
        tick();
        status_valid = 1'b0;
        check("s2_pend_set", 32'(pend), 32'd1);
        run_until_last(18);
        check("s2_rows_old", 32'(rows), 32'(7'b0111110));
        check("s2_pend_hold", 32'(pend), 32'd1);
        run_until_last(1);
        check("s2_rows_new", 32'(rows), 32'(7'b1100011));
        check("s2_pend_clr", 32'(pend), 32'd0);

        // Two captures then one exactly on the wrap edge.
        status_valid = 1'b1; status_in = 2'd1;
        tick();
        status_in = 2'd3;
        tick();
        status_valid = 1'b0;
        check("s3_pend", 32'(pend), 32'd1);
        run_until_last(18);
        status_valid = 1'b1; status_in = 2'd2;
        tick();
        status_valid = 1'b0;
        check("s3_wrap_pend", 32'(pend), 32'd0);
        run_until_last(1);
        check("s3_rows_c0", 32'(rows), 32'(7'b1100011));
        run_until_last(9);
        check("s3_rows_c2", 32'(rows), 32'(7'b0001000));

        // Code 3 is defined for dut but out of range for dut3.
        status_valid = 1'b1; status_in = 2'd3;
        tick();
        status_valid = 1'b0;
        run_until_last(9);
        check("s4_rows", 32'(rows), 32'(7'b1110000));
        check("s4_rows3", 32'(rows3), 32'd0);
        check("s4_cols3", 32'(cols3), 32'(5'b00100));

        // Blink: two frames visible, two blank.
        run_until_last(0);
        blink_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_until_last(1);
            check("s5_blink", 32'(rows), (i % 4 < 2) ? 32'(7'b1000000) : 32'd0);
        end
        run_until_last(6);
        check("s5_blank", 32'(rows), 32'd0);
        blink_en = 1'b0;
        tick();
        check("s5_restore", 32'(rows), 32'(7'b1100000));

        // Reset mid-frame after dead time, with a capture pending.
        status_valid = 1'b1; status_in = 2'd1;
        tick();
        status_valid = 1'b0;
        run_until_last(13);
        check("s6_pre_pend", 32'(pend), 32'd1);
        rst_n = 1'b0;
        tick();
        check("s6_cols", 32'(cols), 32'd0);
        check("s6_rows", 32'(rows), 32'd0);
        check("s6_fs",   32'(fs),   32'd0);
        check("s6_pend", 32'(pend), 32'd0);
        rst_n = 1'b1;
        tick();
        check("s6_rel_cols", 32'(cols), 32'(5'b00001));
        check("s6_rel_fs",   32'(fs),   32'd1);
        tick();
        check("s6_rel_rows", 32'(rows), 32'(7'b0111110));

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            status_valid = ($urandom_range(0, 7) == 0);
            status_in    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) blink_en = ~blink_en;
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
